// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and
// helpers that size the step counter from WIDTH/DIGIT.
package serial_adder_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

  // Number of digit steps needed for a full-width result.
  function automatic int calc_steps(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter width; at least one bit so STEPS=1 still has a legal counter.
  function automatic int cnt_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// 1-bit full adder cell used to build the per-cycle digit chain.
//  x, y : operand bits
//  ci   : carry in
//  s    : sum bit
//  co   : carry out
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract unit. DIGIT bits are summed per clock through a
// chain of fa_cell instances; a WIDTH-bit result completes in WIDTH/DIGIT
// RUN cycles and is announced by a one-cycle done pulse.
//  clk, rst_n        : clock, async active-low reset
//  start             : request, accepted when ready=1
//  sub               : 0 a+b+ci, 1 a-b-ci (ci is borrow-in)
//  a, b, ci          : operands, captured on accept
//  ready / busy      : can accept / operation in progress
//  done              : result outputs just updated
//  sum, co, ovf      : result, carry-out (sub: 1 = no borrow), signed overflow
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int STEPS = calc_steps(WIDTH, DIGIT);
  localparam int CW    = cnt_width(STEPS);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_opa, r_opb, r_res, r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_co, r_ovf;

  logic [DIGIT:0]   w_c;
  logic [DIGIT-1:0] w_s;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_accept, w_last, w_ready;

  // Carry chain across the digit; w_c[0] is the carry held between cycles.
  assign w_c[0] = r_carry;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    fa_cell u_fa (
      .x  (r_opa[i]),
      .y  (r_opb[i]),
      .ci (w_c[i]),
      .s  (w_s[i]),
      .co (w_c[i+1])
    );
  end

  // New digit enters from the MSB side so the LSB digit ends up at bit 0.
  assign w_res_nxt = WIDTH'({w_s, r_res} >> DIGIT);

  assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_accept = start & w_ready;
  assign w_last   = (r_state == ST_RUN) && (r_cnt == CW'(STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = start ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction as a + ~b + ~ci: invert B and the borrow once up front.
      r_opa   <= a;
      r_opb   <= b ^ {WIDTH{sub}};
      r_carry <= ci ^ sub;
      r_cnt   <= '0;
      r_res   <= '0;
    end else if (r_state == ST_RUN) begin
      r_opa   <= r_opa >> DIGIT;
      r_opb   <= r_opb >> DIGIT;
      r_res   <= w_res_nxt;
      r_carry <= w_c[DIGIT];
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum <= w_res_nxt;
        r_co  <= w_c[DIGIT];
        // On the last step the top cell of the chain is the result MSB.
        r_ovf <= w_c[DIGIT-1] ^ w_c[DIGIT];
      end
    end
  end

  assign ready = w_ready;
  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);
  assign sum   = r_sum;
  assign co    = r_co;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  // WIDTH=8, DIGIT=1 instance
  logic       start, sub, ci;
  logic [7:0] a, b, sum;
  logic       ready, busy, done, co, ovf;
  // WIDTH=8, DIGIT=4 instance
  logic       start4, sub4, ci4;
  logic [7:0] a4, b4, sum4;
  logic       ready4, busy4, done4, co4, ovf4;

  int ncmp = 0;
  int nerr = 0;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .co(co), .ovf(ovf)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4), .ci(ci4),
    .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .co(co4), .ovf(ovf4)
  );

  // Reference: integer arithmetic, result packed as {ovf, co, sum}.
  function automatic logic [9:0] ref_op(input logic [7:0] ra, input logic [7:0] rb,
                                        input logic rci, input logic rsub);
    int u, s;
    logic [7:0] r;
    logic c, v;
    if (!rsub) begin
      u = int'(ra) + int'(rb) + int'(rci);
      s = int'($signed(ra)) + int'($signed(rb)) + int'(rci);
      c = (u > 255);
    end else begin
      u = int'(ra) - int'(rb) - int'(rci);
      s = int'($signed(ra)) - int'($signed(rb)) - int'(rci);
      c = (u >= 0);
    end
    r = u[7:0];
    v = (s > 127) || (s < -128);
    return {v, c, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation on the DIGIT=1 instance. Outputs are sampled on negedges.
  // lat counts clock edges after the accept edge until done is seen.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tci,
                       input logic tsub, input bit inject);
    logic [9:0] e;
    int lat;
    e = ref_op(ta, tb, tci, tsub);
    @(negedge clk);
    chk("ready_before", ready, 1);
    a = ta; b = tb; ci = tci; sub = tsub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // operands may change freely once accepted
    a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom); sub = 1'($urandom);
    chk("busy_run", busy, 1);
    chk("ready_run0", ready, 0);
    lat = 0;
    while (!done && lat < 40) begin
      start = (inject && lat == 3);
      if (start) begin
        a = 8'($urandom); b = 8'($urandom);
      end
      @(negedge clk);
      lat++;
      if (!done) chk("ready_run", ready, 0);
    end
    start = 1'b0;
    chk("latency", lat, 8);
    chk("sum", sum, e[7:0]);
    chk("co", co, e[8]);
    chk("ovf", ovf, e[9]);
    @(negedge clk);
    chk("done_single", done, 0);
    chk("ready_after", ready, 1);
    chk("sum_held", sum, e[7:0]);
  endtask

  initial begin
    logic [9:0] e;
    logic [9:0] q[$];
    int last, ndone;

    rst_n = 1'b0;
    start = 0; sub = 0; ci = 0; a = 0; b = 0;
    start4 = 0; sub4 = 0; ci4 = 0; a4 = 0; b4 = 0;
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_co", co, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed corner cases
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'h05, 8'h07, 1'b0, 1'b1, 0);
    do_op(8'h80, 8'h01, 1'b0, 1'b1, 0);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'h10, 8'h20, 1'b1, 1'b0, 0);
    // random operands, both modes, with carry/borrow in
    for (int i = 0; i < 12; i++)
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 0);
    // start during RUN is ignored
    do_op(8'h23, 8'h11, 1'b0, 1'b0, 1);

    // reset in the middle of RUN aborts with no done
    @(negedge clk);
    a = 8'hC3; b = 8'h5A; ci = 0; sub = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_pre_abort", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_co", co, 0);
    chk("abort_ovf", ovf, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    rst_n = 1'b1;
    do_op(8'h01, 8'h01, 1'b0, 1'b0, 0);

    // DIGIT=4: 9C+6F then back-to-back with start held high
    @(negedge clk);
    a4 = 8'h9C; b4 = 8'h6F; ci4 = 0; sub4 = 0; start4 = 1'b1;
    q.push_back(ref_op(8'h9C, 8'h6F, 1'b0, 1'b0));
    last = 0;
    ndone = 0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      if (done4) begin
        ndone++;
        // 3 cycles from the cycle start was presented to the done cycle
        chk("d4_spacing", cyc - last, 3);
        last = cyc;
        chk("d4_q_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("d4_sum", sum4, e[7:0]);
          chk("d4_co", co4, e[8]);
          chk("d4_ovf", ovf4, e[9]);
        end
        if (ndone < 4) begin
          chk("d4_ready", ready4, 1);
          a4 = 8'($urandom); b4 = 8'($urandom); ci4 = 1'($urandom); sub4 = 1'($urandom);
          q.push_back(ref_op(a4, b4, ci4, sub4));
        end else begin
          start4 = 1'b0;
        end
      end
    end
    chk("d4_count", ndone, 4);
    chk("d4_idle", ready4 && !busy4, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
